zx_matrix_scanner: RTL and testbench

Scans a physical or virtual ZX Spectrum 8×5 key matrix, debounces every key, and emits press/release events in the 11-bit `ps2_key` event format that the core's PS/2-to-matrix keyboard decoder consumes. It sits in front of that decoder, so a real Spectrum keyboard or membrane can drive the core through the same event path as a PS/2 keyboard. Detected changes are queued in a FIFO and emitted one at a time with a guaranteed minimum spacing.

---
 rtl/zx_matrix_scanner_if.sv | 11 +
 rtl/zx_matrix_scanner.sv | 207 ++++++++++++++++++++
 tb/tb_zx_matrix_scanner.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/zx_matrix_scanner_if.sv
// Key-matrix bus between the matrix scanner and its keyboard/consumer side.
// Carries the row drive, column return and the ps2_key event output.
interface zx_matrix_scanner_if;
  logic [7:0]  row_sel;
  logic [4:0]  col_in;
  logic [10:0] ps2_key;
  logic        overflow;

  modport master (output row_sel, output ps2_key, output overflow, input col_in);
  modport slave  (input row_sel, input ps2_key, input overflow, output col_in);
endinterface

// File: rtl/zx_matrix_scanner.sv
// ZX Spectrum 8x5 matrix scanner with per-key debounce, event FIFO and paced ps2_key emitter.
// Define MATRIX_SYNC_EN to pass col_in through a 2-flop synchroniser before capture.
module zx_matrix_scanner #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4,
  parameter int EVT_GAP  = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  zx_matrix_scanner_if.master  bus
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int GAP_W = $clog2(EVT_GAP);
  localparam logic [2:0] DEB = 3'(DEBOUNCE);

  typedef enum logic {SETTLE, WALK} state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [2:0]       row_reg, row_next;
  logic [2:0]       col_reg, col_next;
  logic [4:0]       samp_reg, samp_next;
  logic             started_reg;
  logic             walk;
  logic [4:0]       col_sync;

`ifdef MATRIX_SYNC_EN
  logic [4:0] sync1_reg, sync2_reg;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= bus.col_in;
      sync2_reg <= sync1_reg;
    end
  end
  assign col_sync = sync2_reg;
`else
  assign col_sync = bus.col_in;
`endif

  function automatic logic [7:0] scancode(input logic [5:0] idx);
    case (idx)
      6'd0:  return 8'h12; 6'd1:  return 8'h1A; 6'd2:  return 8'h22; 6'd3:  return 8'h21; 6'd4:  return 8'h2A;
      6'd5:  return 8'h1C; 6'd6:  return 8'h1B; 6'd7:  return 8'h23; 6'd8:  return 8'h2B; 6'd9:  return 8'h34;
      6'd10: return 8'h15; 6'd11: return 8'h1D; 6'd12: return 8'h24; 6'd13: return 8'h2D; 6'd14: return 8'h2C;
      6'd15: return 8'h16; 6'd16: return 8'h1E; 6'd17: return 8'h26; 6'd18: return 8'h25; 6'd19: return 8'h2E;
      6'd20: return 8'h45; 6'd21: return 8'h46; 6'd22: return 8'h3E; 6'd23: return 8'h3D; 6'd24: return 8'h36;
      6'd25: return 8'h4D; 6'd26: return 8'h44; 6'd27: return 8'h43; 6'd28: return 8'h3C; 6'd29: return 8'h35;
      6'd30: return 8'h5A; 6'd31: return 8'h4B; 6'd32: return 8'h42; 6'd33: return 8'h3B; 6'd34: return 8'h33;
      6'd35: return 8'h29; 6'd36: return 8'h14; 6'd37: return 8'h3A; 6'd38: return 8'h31; 6'd39: return 8'h32;
      default: return 8'h00;
    endcase
  endfunction

  // Scan FSM is held idle for the first clock so row 0 gets a full SCAN_DIV drive.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= SETTLE;
      div_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      samp_reg    <= '1;
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      samp_reg    <= samp_next;
      started_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    samp_next  = samp_reg;
    walk       = 1'b0;
    if (started_reg) begin
      case (state_reg)
        SETTLE: begin
          if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
            samp_next  = col_sync;
            div_next   = '0;
            col_next   = '0;
            state_next = WALK;
          end else begin
            div_next = div_reg + 1'b1;
          end
        end
        WALK: begin
          walk = 1'b1;
          if (col_reg == 3'd4) begin
            col_next   = '0;
            row_next   = row_reg + 1'b1;
            state_next = SETTLE;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
        default: state_next = SETTLE;
      endcase
    end
  end

  assign bus.row_sel = started_reg ? ~(8'd1 << row_reg) : 8'hFF;

  logic [5:0]  key_idx;
  logic        raw;
  logic [39:0] stable_vec;
  logic [2:0]  cnt_vec [40];
  logic [2:0]  cnt_inc, key_cnt_next;
  logic        commit, refused, push_ok, pop;

  assign key_idx = 6'(row_reg) * 6'd5 + 6'(col_reg);
  assign raw     = ~samp_reg[col_reg];

  always_comb begin
    cnt_inc      = cnt_vec[key_idx];
    key_cnt_next = cnt_vec[key_idx];
    commit       = 1'b0;
    refused      = 1'b0;
    if (walk) begin
      if (raw == stable_vec[key_idx]) begin
        key_cnt_next = '0;
      end else begin
        cnt_inc = (cnt_vec[key_idx] == DEB) ? DEB : cnt_vec[key_idx] + 1'b1;
        if (cnt_inc == DEB) begin
          if (push_ok) begin
            commit       = 1'b1;
            key_cnt_next = '0;
          end else begin
            refused      = 1'b1;
            key_cnt_next = DEB;
          end
        end else begin
          key_cnt_next = cnt_inc;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 40; gi++) begin : g_key
      logic       stable_reg;
      logic [2:0] cnt_reg;
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else if (walk && key_idx == 6'(gi)) begin
          cnt_reg <= key_cnt_next;
          if (commit) stable_reg <= raw;
        end
      end
      assign stable_vec[gi] = stable_reg;
      assign cnt_vec[gi]    = cnt_reg;
    end
  endgenerate

  logic [8:0]       fifo_mem [8];
  logic [2:0]       wr_ptr_reg, rd_ptr_reg;
  logic [3:0]       fifo_cnt_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [10:0]      ps2_reg;
  logic             overflow_reg;
  logic [8:0]       entry;

  // A full FIFO still accepts a push when the emitter pops in the same cycle.
  assign pop     = (fifo_cnt_reg != 4'd0) && (gap_reg == '0);
  assign push_ok = (fifo_cnt_reg != 4'd8) || pop;
  assign entry   = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk_sys) begin
    if (commit) fifo_mem[wr_ptr_reg] <= {raw, scancode(key_idx)};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      gap_reg      <= '0;
      ps2_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (commit) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      fifo_cnt_reg <= fifo_cnt_reg + {3'b0, commit} - {3'b0, pop};
      if (pop) begin
        ps2_reg <= {~ps2_reg[10], entry[8], 1'b0, entry[7:0]};
        gap_reg <= GAP_W'(EVT_GAP - 1);
      end else if (gap_reg != '0) begin
        gap_reg <= gap_reg - 1'b1;
      end
      if (refused) overflow_reg <= 1'b1;
    end
  end

  assign bus.ps2_key  = ps2_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_zx_matrix_scanner.sv
// Self-checking bench for zx_matrix_scanner: directed tables and sequences plus random key traffic
// compared every cycle against a timing-arithmetic reference model.
module tb_zx_matrix_scanner;
  localparam int SCAN_DIV = 16;
  localparam int DEBOUNCE = 4;
  localparam int EVT_GAP  = 16;
  localparam int PERIOD   = SCAN_DIV + 5;
`ifdef MATRIX_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  zx_matrix_scanner_if mx();
  zx_matrix_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .EVT_GAP(EVT_GAP))
    dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(mx.master));

  bit keys [8][5];
  always_comb begin
    mx.col_in = '1;
    for (int r = 0; r < 8; r++)
      if (!mx.row_sel[r])
        for (int c = 0; c < 5; c++)
          if (keys[r][c]) mx.col_in[c] = 1'b0;
  end

  logic [7:0] code_tab [40];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: key (r,c) of global row k is sampled at clock 17+21k (minus sync delay)
  // and judged at clock 18+21k+c; events leave a FIFO of 8 no closer than EVT_GAP clocks.
  int          t;
  bit          m_stable [40];
  int          m_cnt [40];
  logic [8:0]  m_q [$];
  int          m_last;
  logic [10:0] m_ps2;
  bit          m_ovf;
  bit          snap [5];
  bit          pop_now;
  int          mk, mph, mi;
  logic [8:0]  me;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      t = 0;
      for (int i = 0; i < 40; i++) begin m_stable[i] = 0; m_cnt[i] = 0; end
      m_q.delete();
      m_last = -1000;
      m_ps2  = '0;
      m_ovf  = 0;
    end else begin
      t++;
      pop_now = (m_q.size() > 0) && (t - m_last >= EVT_GAP);
      if (t >= 17 - SYNC_D && ((t - 17 + SYNC_D) % PERIOD) == 0) begin
        mk = (t - 17 + SYNC_D) / PERIOD;
        for (int c = 0; c < 5; c++) snap[c] = keys[mk % 8][c];
      end
      if (t >= 18 && ((t - 18) % PERIOD) < 5) begin
        mk  = (t - 18) / PERIOD;
        mph = (t - 18) % PERIOD;
        mi  = (mk % 8) * 5 + mph;
        if (snap[mph] == m_stable[mi]) begin
          m_cnt[mi] = 0;
        end else begin
          m_cnt[mi] = (m_cnt[mi] + 1 > DEBOUNCE) ? DEBOUNCE : m_cnt[mi] + 1;
          if (m_cnt[mi] == DEBOUNCE) begin
            if (m_q.size() - (pop_now ? 1 : 0) < 8) begin
              m_q.push_back({snap[mph], code_tab[mi]});
              m_stable[mi] = snap[mph];
              m_cnt[mi] = 0;
            end else begin
              m_ovf = 1;
            end
          end
        end
      end
      if (pop_now) begin
        me = m_q.pop_front();
        m_ps2 = {~m_ps2[10], me[8], 1'b0, me[7:0]};
        m_last = t;
      end
    end
  end

  logic [10:0] ev_key [$];
  int          ev_t [$];
  int          tog_cnt = 0;
  logic        prev10 = 1'b0;

  always @(negedge clk_sys) begin
    if (reset_n && t > 0) begin
      chk("ps2_key_vs_model", 32'(mx.ps2_key), 32'(m_ps2));
      chk("overflow_vs_model", 32'(mx.overflow), 32'(m_ovf));
      if (mx.ps2_key[10] != prev10) begin
        ev_key.push_back(mx.ps2_key);
        ev_t.push_back(t);
        tog_cnt++;
        $display("[TB] event t=%0d ps2_key=%03h", t, mx.ps2_key);
      end
      prev10 = mx.ps2_key[10];
    end
  end

  function automatic logic [10:0] evk(input int i);
    if (i < ev_key.size()) return ev_key[i];
    return 11'h7FF;
  endfunction
  function automatic int evt(input int i);
    if (i < ev_t.size()) return ev_t[i];
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_sys); #2; end
  endtask

  task automatic set_all(input bit v);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++) keys[r][c] = v;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(3);
    ev_key.delete();
    ev_t.delete();
    tog_cnt = 0;
    prev10  = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic wait_tog(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (tog_cnt < n && i < budget) begin step(1); i++; end
    chk(name, 32'(tog_cnt >= n), 32'd1);
  endtask

  typedef struct {
    int         r;
    int         c;
    logic [9:0] press;
    logic [9:0] rel;
  } vec_t;
  vec_t vecs [8];
  int   hits;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    code_tab = '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
                 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                 8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36, 8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
                 8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33, 8'h29, 8'h14, 8'h3A, 8'h31, 8'h32};
    vecs[0] = '{0, 4, 10'h22A, 10'h02A};
    vecs[1] = '{1, 2, 10'h223, 10'h023};
    vecs[2] = '{2, 3, 10'h22D, 10'h02D};
    vecs[3] = '{3, 0, 10'h216, 10'h016};
    vecs[4] = '{4, 1, 10'h246, 10'h046};
    vecs[5] = '{5, 4, 10'h235, 10'h035};
    vecs[6] = '{6, 0, 10'h25A, 10'h05A};
    vecs[7] = '{7, 1, 10'h214, 10'h014};

    // Z held from reset
    set_all(0);
    keys[0][1] = 1;
    reset_n = 1'b0;
    step(3);
    chk("reset_row_sel", 32'(mx.row_sel), 32'h0FF);
    chk("reset_ps2_key", 32'(mx.ps2_key), 32'h000);
    chk("reset_overflow", 32'(mx.overflow), 32'h0);
    reset_n = 1'b1;
    step(1);
    chk("first_row_drive", 32'(mx.row_sel), 32'h0FE);
    step(1199);
    chk("z_toggle_count", 32'(tog_cnt), 32'd1);
    chk("z_press_code", 32'(evk(0) & 11'h3FF), 32'h21A);
    chk("z_press_time", 32'(evt(0)), 32'd524);
    keys[0][1] = 0;
    wait_tog(2, 1000, "z_release_timeout");
    chk("z_release_code", 32'(evk(1) & 11'h3FF), 32'h01A);

    // A pulse shorter than the debounce window
    keys[1][0] = 1;
    step(3 * 8 * PERIOD);
    keys[1][0] = 0;
    step(900);
    chk("a_short_no_event", 32'(tog_cnt), 32'd2);
    chk("a_short_overflow", 32'(mx.overflow), 32'd0);

    // Single-key table, one key per row
    for (int v = 0; v < 8; v++) begin
      keys[vecs[v].r][vecs[v].c] = 1;
      wait_tog(tog_cnt + 1, 1200, "table_press_timeout");
      chk("table_press_code", 32'(evk(tog_cnt - 1) & 11'h3FF), 32'(vecs[v].press));
      keys[vecs[v].r][vecs[v].c] = 0;
      wait_tog(tog_cnt + 1, 1200, "table_release_timeout");
      chk("table_release_code", 32'(evk(tog_cnt - 1) & 11'h3FF), 32'(vecs[v].rel));
    end

    // Random key traffic against the model
    for (int p = 0; p < 8; p++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 5; c++) keys[r][c] = ($urandom_range(9) == 0);
      step($urandom_range(700, 150));
    end
    set_all(0);
    step(1200);

    // Caps shift, Z, X, C, V together
    keys[0][0] = 1; keys[0][1] = 1; keys[0][2] = 1; keys[0][3] = 1; keys[0][4] = 1;
    do_reset();
    wait_tog(5, 1500, "row0_timeout");
    chk("row0_code0", 32'(evk(0) & 11'h3FF), 32'h212);
    chk("row0_code1", 32'(evk(1) & 11'h3FF), 32'h21A);
    chk("row0_code2", 32'(evk(2) & 11'h3FF), 32'h222);
    chk("row0_code3", 32'(evk(3) & 11'h3FF), 32'h221);
    chk("row0_code4", 32'(evk(4) & 11'h3FF), 32'h22A);
    for (int i = 1; i < 5; i++)
      chk("row0_spacing", 32'(evt(i) - evt(i - 1)), 32'(EVT_GAP));
    set_all(0);
    wait_tog(10, 1500, "row0_release_timeout");

    // All 40 keys at once
    set_all(1);
    do_reset();
    wait_tog(40, 6000, "all40_timeout");
    step(600);
    chk("all40_event_count", 32'(tog_cnt), 32'd40);
    for (int k = 0; k < 40; k++) begin
      hits = 0;
      for (int e = 0; e < ev_key.size(); e++)
        if (ev_key[e][9:0] == {2'b10, code_tab[k]}) hits++;
      chk("all40_code_once", 32'(hits), 32'd1);
    end
    chk("all40_overflow", 32'(mx.overflow), 32'd1);

    // Reset with events queued, keys still held
    do_reset();
    wait_tog(3, 1000, "midreset_timeout");
    reset_n = 1'b0;
    #1;
    chk("midreset_ps2_key", 32'(mx.ps2_key), 32'h000);
    chk("midreset_row_sel", 32'(mx.row_sel), 32'h0FF);
    chk("midreset_overflow", 32'(mx.overflow), 32'h0);
    step(2);
    ev_key.delete();
    ev_t.delete();
    tog_cnt = 0;
    prev10  = 1'b0;
    reset_n = 1'b1;
    wait_tog(1, 1000, "rereport_timeout");
    chk("rereport_first", 32'(evk(0)), 32'h612);
    set_all(0);
    step(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
